// File: rtl/cnn_stream_pkg.sv
// Shared definitions for the tagged IFMap stream: tag encodings, the writer
// state enum and the word-assembly helper macro.
`ifndef CNN_STREAM_WORD
`define CNN_STREAM_WORD(tag, data) {(tag), (data)}
`endif

package cnn_stream_pkg;

  localparam logic [1:0] TAG_SOR    = 2'b10;
  localparam logic [1:0] TAG_EOR    = 2'b01;
  localparam logic [1:0] TAG_MID    = 2'b00;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } wr_state_e;

  // Tag for an element given whether it opens and/or closes its row.
  function automatic logic [1:0] stream_tag(input logic first, input logic last);
    logic [1:0] t;
    case ({first, last})
      2'b10:   t = TAG_SOR;
      2'b01:   t = TAG_EOR;
      2'b11:   t = TAG_SINGLE;
      default: t = TAG_MID;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/stream_addr_gen.sv
// Row/column counters for the IFMap stream writer. Holds the address of the
// next element to read and flags whether it opens a row, closes a row, or is
// the final element of the region. Addresses wrap modulo 2^AW.
module stream_addr_gen
  import cnn_stream_pkg::*;
#(
  parameter int AW = 5,
  parameter int LW = 5,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          adv,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] pitch,
  input  logic [LW-1:0] len,
  input  logic [RW-1:0] rows,
  output logic [AW-1:0] addr,
  output logic          first,
  output logic          last_col,
  output logic          last_all
);

  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [AW-1:0] pitch_q, pitch_d;
  logic [LW-1:0] col_q, col_d;
  logic [LW-1:0] len_q, len_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] rows_q, rows_d;

  assign addr     = addr_q;
  assign first    = (col_q == '0);
  assign last_col = (col_q == len_q - LW'(1));
  assign last_all = last_col && (row_q == rows_q - RW'(1));

  // Next-state: latch configuration on load, otherwise step one element per adv.
  always_comb begin
    addr_d     = addr_q;
    row_base_d = row_base_q;
    pitch_d    = pitch_q;
    col_d      = col_q;
    len_d      = len_q;
    row_d      = row_q;
    rows_d     = rows_q;
    if (load) begin
      addr_d     = base;
      row_base_d = base;
      pitch_d    = pitch;
      len_d      = len;
      rows_d     = rows;
      col_d      = '0;
      row_d      = '0;
    end else if (adv) begin
      if (last_col) begin
        row_base_d = row_base_q + pitch_q;
        addr_d     = row_base_q + pitch_q;
        col_d      = '0;
        row_d      = row_q + RW'(1);
      end else begin
        addr_d = addr_q + AW'(1);
        col_d  = col_q + LW'(1);
      end
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      row_base_q <= '0;
      pitch_q    <= '0;
      col_q      <= '0;
      len_q      <= '0;
      row_q      <= '0;
      rows_q     <= '0;
    end else begin
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      pitch_q    <= pitch_d;
      col_q      <= col_d;
      len_q      <= len_d;
      row_q      <= row_d;
      rows_q     <= rows_d;
    end
  end

endmodule

// File: rtl/ifmap_stream_writer.sv
// Reads a rectangular IFMap region from a synchronous-read scratch memory and
// writes it row by row into the IFMap circular buffer as {sor, eor, data}
// words. Optional macro IFMAP_WR_ROWPITCH_EN adds a row_pitch port so rows
// can be a sub-window of a wider stored map; without it rows are contiguous.
module ifmap_stream_writer
  import cnn_stream_pkg::*;
#(
  parameter int DATA_WIDTH       = 10,
  parameter int IFMAP_ADDR_WIDTH = 5,
  parameter int LEN_WIDTH        = 5,
  parameter int ROWS_WIDTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [IFMAP_ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]        row_len,
  input  logic [ROWS_WIDTH-1:0]       num_rows,
`ifdef IFMAP_WR_ROWPITCH_EN
  input  logic [IFMAP_ADDR_WIDTH-1:0] row_pitch,
`endif
  output logic                        mem_ren,
  output logic [IFMAP_ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  input  logic                        ready_IFMap,
  output logic                        wen_buf_IFMap,
  output logic [DATA_WIDTH+1:0]       IFMap_word,
  output logic                        busy,
  output logic                        done
);

  wr_state_e state_q, state_d;

  logic                        accept;
  logic                        degenerate;
  logic                        adv;
  logic                        first;
  logic                        last_col;
  logic                        last_all;
  logic [IFMAP_ADDR_WIDTH-1:0] pitch_sel;
  logic [IFMAP_ADDR_WIDTH-1:0] gen_addr;
  // Tag and end-of-region flag of the word whose read is in flight.
  logic [1:0]                  tag_q;
  logic                        last_q;

  assign accept     = (state_q == S_IDLE) && start;
  assign degenerate = (row_len == '0) || (num_rows == '0);
  assign mem_addr   = gen_addr;

`ifdef IFMAP_WR_ROWPITCH_EN
  assign pitch_sel = row_pitch;
`else
  assign pitch_sel = IFMAP_ADDR_WIDTH'(row_len);
`endif

  stream_addr_gen #(
    .AW(IFMAP_ADDR_WIDTH),
    .LW(LEN_WIDTH),
    .RW(ROWS_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .adv     (adv),
    .base    (base_addr),
    .pitch   (pitch_sel),
    .len     (row_len),
    .rows    (num_rows),
    .addr    (gen_addr),
    .first   (first),
    .last_col(last_col),
    .last_all(last_all)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = degenerate ? S_DONE : S_RD;
      S_RD:   state_d = S_WR;
      S_WR:   if (ready_IFMap && last_q) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; in WR the write and the follow-on read track ready_IFMap directly.
  always_comb begin
    mem_ren       = 1'b0;
    adv           = 1'b0;
    wen_buf_IFMap = 1'b0;
    IFMap_word    = '0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      S_RD: begin
        busy    = 1'b1;
        mem_ren = 1'b1;
        adv     = 1'b1;
      end
      S_WR: begin
        busy          = 1'b1;
        IFMap_word    = `CNN_STREAM_WORD(tag_q, mem_rdata);
        wen_buf_IFMap = ready_IFMap;
        if (ready_IFMap && !last_q) begin
          mem_ren = 1'b1;
          adv     = 1'b1;
        end
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Capture the position flags of each element as its read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q  <= TAG_MID;
      last_q <= 1'b0;
    end else if (adv) begin
      tag_q  <= stream_tag(first, last_col);
      last_q <= last_all;
    end
  end

endmodule

// File: tb/tb_ifmap_stream_writer.sv
// Bench for ifmap_stream_writer: directed and randomized jobs checked against
// a region-level model of the expected read addresses and tagged words.
module tb_ifmap_stream_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  base_addr;
  logic [4:0]  row_len;
  logic [3:0]  num_rows;
`ifdef IFMAP_WR_ROWPITCH_EN
  logic [4:0]  row_pitch;
`endif
  logic        mem_ren;
  logic [4:0]  mem_addr;
  logic [9:0]  mem_rdata;
  logic        ready_IFMap;
  logic        wen_buf_IFMap;
  logic [11:0] IFMap_word;
  logic        busy;
  logic        done;

  logic [9:0]  mem [32];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  ifmap_stream_writer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .row_len      (row_len),
    .num_rows     (num_rows),
`ifdef IFMAP_WR_ROWPITCH_EN
    .row_pitch    (row_pitch),
`endif
    .mem_ren      (mem_ren),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .ready_IFMap  (ready_IFMap),
    .wen_buf_IFMap(wen_buf_IFMap),
    .IFMap_word   (IFMap_word),
    .busy         (busy),
    .done         (done)
  );

  // Synchronous-read scratch memory: data appears the cycle after mem_ren.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ren"},  {31'd0, mem_ren}, 0);
    check({tag, "_wen"},  {31'd0, wen_buf_IFMap}, 0);
    check({tag, "_word"}, {20'd0, IFMap_word}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
  endtask

  // Runs one job. stall_at/stall_len: hold ready low for stall_len cycles once
  // stall_at words are written. inj_cyc: pulse a second start in that cycle.
  // rst_after: abandon the job once that many words are written.
  task automatic run_job(input int base, input int len, input int rows, input int pitch,
                         input int stall_at, input int stall_len, input bit rnd_ready,
                         input int inj_cyc, input int rst_after);
    int exp_w[$];
    int exp_a[$];
    int pe, a, rl, writes, stalled, stalls;
    bit seen_done;
`ifdef IFMAP_WR_ROWPITCH_EN
    pe = pitch;
`else
    pe = len;
`endif
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < len; c++) begin
        a = (base + r * pe + c) % 32;
        exp_a.push_back(a);
        exp_w.push_back(((c == 0) ? 32'h800 : 0) | ((c == len - 1) ? 32'h400 : 0) | int'(mem[a]));
      end
    end
    rl = len * rows;
    writes = 0; stalled = 0; stalls = 0; seen_done = 0;

    @(negedge clk);
    start = 1'b1;
    base_addr = base[4:0];
    row_len = len[4:0];
    num_rows = rows[3:0];
`ifdef IFMAP_WR_ROWPITCH_EN
    row_pitch = pitch[4:0];
`endif
    ready_IFMap = 1'b1;

    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (cyc == inj_cyc) begin
        start = 1'b1;
        base_addr = base_addr + 5'd5;
        row_len = 5'd2;
        num_rows = 4'd1;
      end else begin
        start = 1'b0;
      end
      if (writes == stall_at && stalled < stall_len) begin
        ready_IFMap = 1'b0;
        stalled++;
      end else begin
        ready_IFMap = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
      end
      #1;
      if (mem_ren) begin
        if (exp_a.size() == 0) check("extra_read", 1, 0);
        else check("rd_addr", {27'd0, mem_addr}, exp_a.pop_front());
      end
      if (!ready_IFMap && cyc > 1) check("ren_in_stall", {31'd0, mem_ren}, 0);
      if (wen_buf_IFMap) begin
        check("wen_needs_ready", {31'd0, ready_IFMap}, 1);
        if (exp_w.size() == 0) check("extra_write", 1, 0);
        else check("word", {20'd0, IFMap_word}, exp_w.pop_front());
        writes++;
      end else if (!ready_IFMap && cyc > 1 && !done && rl > 0) begin
        stalls++;
        if (exp_w.size() != 0) check("held_word", {20'd0, IFMap_word}, exp_w[0]);
      end
      if (done) begin
        check("done_cycle", cyc, (rl == 0) ? 1 : 2 + rl + stalls);
        check("busy_at_done", {31'd0, busy}, 0);
        check("words_left", exp_w.size(), 0);
        check("reads_left", exp_a.size(), 0);
        seen_done = 1;
        break;
      end else begin
        check("busy", {31'd0, busy}, 1);
      end
      if (rst_after >= 0 && writes == rst_after) return;
    end
    if (!seen_done) begin
      check("timeout_no_done", 0, 1);
    end else begin
      @(negedge clk);
      start = 1'b0;
      ready_IFMap = 1'b1;
      #1;
      check("done_single_pulse", {31'd0, done}, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    row_len = '0;
    num_rows = '0;
`ifdef IFMAP_WR_ROWPITCH_EN
    row_pitch = '0;
`endif
    ready_IFMap = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 10'($urandom);
    for (int i = 0; i < 16; i++) begin
      case (i % 8)
        0, 6: mem[i] = 10'd1;
        1, 5: mem[i] = 10'd2;
        2, 4: mem[i] = 10'd3;
        3:    mem[i] = 10'd4;
        default: mem[i] = 10'd0;
      endcase
    end
    mem[20] = 10'd5; mem[21] = 10'd6; mem[22] = 10'd7;

    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Contiguous two-row map, ready always high.
    run_job(0, 8, 2, 8, -1, 0, 0, -1, -1);
    // Backpressure after the 4th write for 3 cycles.
    run_job(0, 8, 2, 8, 4, 3, 0, -1, -1);
    // Single-element rows.
    run_job(20, 1, 3, 1, -1, 0, 0, -1, -1);
    // Degenerate configurations.
    run_job(3, 0, 2, 0, -1, 0, 0, -1, -1);
    run_job(3, 4, 0, 4, -1, 0, 0, -1, -1);
    // Start pulse while busy must not disturb the stream.
    run_job(0, 8, 2, 8, -1, 0, 0, 5, -1);

    // Reset mid-row after the 3rd write, then restart from base.
    run_job(0, 8, 2, 8, -1, 0, 0, -1, 3);
    @(negedge clk);
    start = 1'b0;
    ready_IFMap = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    check("mid_reset_addr", {27'd0, mem_addr}, 0);
    run_job(0, 8, 2, 8, -1, 0, 0, -1, -1);

`ifdef IFMAP_WR_ROWPITCH_EN
    // Pitched sub-window wrapping past the top of the address space.
    run_job(30, 3, 2, 4, -1, 0, 0, -1, -1);
`endif

    // Randomized jobs with random ready.
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 32; i++) mem[i] = 10'($urandom);
      run_job($urandom_range(31), $urandom_range(8), $urandom_range(4), $urandom_range(31),
              -1, 0, 1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
